// File: rtl/fsm_stim_pkg.sv
// Shared definitions for the example-FSM stimulus driver: state encoding,
// pattern modes and the per-step (a,b) pattern table.
package fsm_stim_pkg;

    localparam int STEPS_PER_FRAME = 4;
    localparam logic [1:0] LAST_STEP = 2'(STEPS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] MODE_ZERO  = 2'd0;  // 00,00,00,00
    localparam logic [1:0] MODE_PULSE = 2'd1;  // 11,00,00,00
    localparam logic [1:0] MODE_S1    = 2'd2;  // 10,10,00,00
    localparam logic [1:0] MODE_MIX   = 2'd3;  // 11,00,10,10

    // (a,b) for a given mode and step; every pattern leaves the target in s0.
    function automatic logic [1:0] pattern_ab(input logic [1:0] mode,
                                              input logic [1:0] step);
        logic [1:0] ab;
        ab = 2'b00;
        case (mode)
            MODE_PULSE: ab = (step == 2'd0) ? 2'b11 : 2'b00;
            MODE_S1:    ab = (!step[1]) ? 2'b10 : 2'b00;
            MODE_MIX: begin
                case (step)
                    2'd0:    ab = 2'b11;
                    2'd1:    ab = 2'b00;
                    default: ab = 2'b10;
                endcase
            end
            default:    ab = 2'b00;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/fsm_eg_stim_driver_if.sv
// Target-facing signals: stimulus a/b out to the example FSM, y0/y1 back.
// a/b change only on the driver's clock edge; y0 may depend combinationally
// on a/b and the target state, y1 only on the target state.
interface fsm_eg_stim_driver_if;
    logic a;
    logic b;
    logic y0;
    logic y1;

    modport master (output a, output b, input y0, input y1);
    modport slave  (input a, input b, output y0, output y1);
endinterface

// File: rtl/fsm_stim_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module fsm_stim_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, else step by one unless already at the top value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/fsm_eg_stim_driver.sv
// Drives framed a/b patterns into the example 3-state FSM and counts its
// Mealy pulses (y0) and Moore high cycles (y1) while a run is active.
module fsm_eg_stim_driver
    import fsm_stim_pkg::*;
#(
    parameter int REP_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [REP_W-1:0]       reps,
    fsm_eg_stim_driver_if.master   tgt,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       pulse_cnt,
    output logic [CNT_W-1:0]       hi_cnt,
    output state_e                 state_dbg
);

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [1:0]       step_q, step_d;
    logic [REP_W-1:0] frame_q, frame_d;
    logic [1:0]       ab_q, ab_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_clear;
    logic             last_step;

    // frame_q only ever climbs to reps_q, so it cannot wrap even at max reps.
    assign last_step = (step_q == LAST_STEP) && (frame_q == reps_q);

    // State and datapath registers, async active-low reset aborts any run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            reps_q  <= '0;
            step_q  <= '0;
            frame_q <= '0;
            ab_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            reps_q  <= reps_d;
            step_q  <= step_d;
            frame_q <= frame_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state: IDLE waits for start, RUN ends on the final step, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_RUN;
            ST_RUN:  if (last_step) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath: stimulus for the next step is registered one edge ahead.
    always_comb begin
        mode_d    = mode_q;
        reps_d    = reps_q;
        step_d    = step_q;
        frame_d   = frame_q;
        ab_d      = 2'b00;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        cnt_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    reps_d    = reps;
                    step_d    = '0;
                    frame_d   = '0;
                    ab_d      = pattern_ab(mode, 2'd0);
                    busy_d    = 1'b1;
                    cnt_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (step_q != LAST_STEP) begin
                    step_d = step_q + 2'd1;
                    ab_d   = pattern_ab(mode_q, step_q + 2'd1);
                    busy_d = 1'b1;
                end else if (frame_q != reps_q) begin
                    frame_d = frame_q + REP_W'(1);
                    step_d  = '0;
                    ab_d    = pattern_ab(mode_q, 2'd0);
                    busy_d  = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    fsm_stim_sat_cnt #(.CNT_W(CNT_W)) u_pulse_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   ((state_q == ST_RUN) && tgt.y0),
        .count (pulse_cnt)
    );

    fsm_stim_sat_cnt #(.CNT_W(CNT_W)) u_hi_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   ((state_q == ST_RUN) && tgt.y1),
        .count (hi_cnt)
    );

    assign tgt.a     = ab_q[1];
    assign tgt.b     = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: doc/fsm_eg_stim_driver.md
Name: fsm_eg_stim_driver

Overview:
- Stimulus/monitor end of the two-input example FSM interface.
- Drives the target's `a`/`b` inputs with programmable frame patterns and counts its Mealy pulse output `y0` and Moore level output `y1`.
- Sits beside the target FSM on the board (switch/LED demo) or in a self-checking bench.
- Target is the 3-state controller:
  - s0 drives `y1=1`. With a=1,b=1 it goes to s2 and pulses `y0`. With a=1,b=0 it goes to s1.
  - s1 drives `y1=1` and returns to s0 when a=1.
  - s2 drives `y1=0` and returns to s0 unconditionally.

Parameters:
- REP_W, 4, width of the frame-repeat field; frames run = reps+1.
- CNT_W, 8, width of each saturating result counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- mode  in  2  pattern select; latched at start.
- reps  in  REP_W  frame repeat count minus one; latched at start.
- y0  in  1  target Mealy output, combinational from target state and a/b.
- y1  in  1  target Moore output.
- a  out  1  registered stimulus to target.
- b  out  1  registered stimulus to target.
- busy  out  1  high while frames are being driven.
- done  out  1  one-cycle pulse after the last step.
- pulse_cnt  out  CNT_W  count of cycles with y0=1 during busy; saturating.
- hi_cnt  out  CNT_W  count of cycles with y1=1 during busy; saturating.

Behaviour:
- Reset (reset=0, async) sets: state IDLE, a=b=0, busy=0, done=0, pulse_cnt=hi_cnt=0. Reset mid-run aborts immediately, and no done pulse is issued.
- States: IDLE, RUN, DONE.
  - IDLE: a=b=0. On an edge with start=1:
    - latch mode and reps;
    - clear both counters;
    - step=0, frame=0;
    - load a/b with step-0 values;
    - busy<=1; go to RUN.
  - RUN: one step per cycle, 4 steps per frame (step 0..3). At each edge:
    - sample y0/y1 into the counters;
    - if step<3: step++ and load a/b for the next step;
    - else if frame<reps: frame++, step=0, load step-0 values;
    - else: a=b=0, busy<=0, done<=1, go to DONE.
  - DONE: done high for exactly one cycle, then IDLE. Counters hold their values until the next start.
- Busy duration is exactly 4*(reps+1) cycles. The first a/b step is visible the cycle after the start edge.
- start while busy or in DONE is ignored. Holding start high in IDLE after DONE begins a new run.
- Pattern table, (a,b) per step 0..3:
  - mode0: 00,00,00,00
  - mode1: 11,00,00,00
  - mode2: 10,10,00,00
  - mode3: 11,00,10,10
  - Every pattern returns the target to s0 by frame end, so frames are independent.
- Counters increment by 1 when their input is high in a RUN cycle. They saturate at 2^CNT_W-1 with no wrap.
- reps at maximum (all ones) gives 2^REP_W frames. The frame counter must not overflow.

Decomposition:
- Package fsm_stim_pkg holds:
  - state encoding constants;
  - mode constants;
  - the 4x4 pattern table as a constant function of (mode, step);
  - STEPS_PER_FRAME=4.
- One natural sub-module, fsm_stim_sat_cnt, parameterised by CNT_W, with clear/inc/count ports and the same async active-low reset. It is instantiated twice, for pulse_cnt and hi_cnt.

Test Plan:
- Reset, then mode1 reps=0 with target attached, start one cycle:
  - a/b sequence is 11,00,00,00;
  - busy is high for 4 cycles, then done pulses for 1 cycle;
  - pulse_cnt=1, hi_cnt=3.
- mode1 reps=2:
  - busy is high for 12 cycles;
  - pulse_cnt=3, hi_cnt=9.
- mode2 reps=0: pulse_cnt=0, hi_cnt=4. mode3 reps=1: pulse_cnt=2, hi_cnt=6.
- CNT_W=4 override, mode0 reps=7: busy is high for 32 cycles; hi_cnt saturates at 15; pulse_cnt=0.
- start pulsed again mid-run in mode1 reps=3:
  - ignored; run completes in 16 cycles with pulse_cnt=4.
  - Then assert reset mid-run: a=b=0, busy=0, counters=0, and no done pulse.
- mode0 reps=15 (maximum): busy is high for exactly 64 cycles, single done pulse, hi_cnt=64.
